// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencer and its datapath.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_core.sv
// Loadable up/down counter; load wins over enable, wraps modulo 2^WIDTH.
module counter_core
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
        else if (en)
            q <= (dir == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run sequencer: FSM, prescaler and run-parameter capture driving counter_core.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t            state, state_n;
    logic [PW-1:0]     pre, pre_n;
    logic              dir_q, ar_q;
    logic [WIDTH-1:0]  load_q, limit_q;
    logic              done_n, capture, cnt_en, cnt_ld, tick;
    logic [WIDTH-1:0]  cnt_d;

    assign tick  = (pre == PW'(PRESCALE - 1));
    assign cnt_d = capture ? load_val : load_q;

    always_comb begin
        state_n = state;
        pre_n   = pre;
        done_n  = 1'b0;
        capture = 1'b0;
        cnt_en  = 1'b0;
        cnt_ld  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_ld  = 1'b1;
                    pre_n   = '0;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // stop freezes the prescaler too, so resume keeps the step phase
                if (stop) begin
                    state_n = ST_PAUSE;
                end else begin
                    pre_n = tick ? '0 : pre + PW'(1);
                    if (tick) begin
                        if (y == limit_q) begin
                            done_n = 1'b1;
                            if (ar_q) cnt_ld  = 1'b1;
                            else      state_n = ST_DONE;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (start && !stop) state_n = ST_RUN;
            end
            ST_DONE: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (start) begin
                    capture = 1'b1;
                    cnt_ld  = 1'b1;
                    pre_n   = '0;
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            pre     <= '0;
            dir_q   <= 1'b0;
            ar_q    <= 1'b0;
            load_q  <= '0;
            limit_q <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            done  <= done_n;
            busy  <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
            if (capture) begin
                dir_q   <= dir;
                ar_q    <= auto_reload;
                load_q  <= load_val;
                limit_q <= limit;
            end
        end
    end

    assign state_o = state;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .load  (cnt_ld),
        .dir   (dir_q),
        .d     (cnt_d),
        .q     (y)
    );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench; two instances (PRESCALE=1 and 3) share stimulus, observed as {state,busy,done,y}.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, dir, auto_reload;
    logic [3:0] load_val, limit;
    logic [3:0] y1, y3;
    logic       busy1, done1, busy3, done3;
    logic [1:0] st1, st3;
    logic [7:0] e;
    int         checks = 0;
    int         errors = 0;

    wire [7:0] obs1 = {st1, busy1, done1, y1};
    wire [7:0] obs3 = {st3, busy3, done3, y3};

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .auto_reload(auto_reload), .load_val(load_val), .limit(limit),
        .y(y1), .busy(busy1), .done(done1), .state_o(st1)
    );

    counter_seq_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .auto_reload(auto_reload), .load_val(load_val), .limit(limit),
        .y(y3), .busy(busy3), .done(done3), .state_o(st3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; auto_reload = 1'b0;
        load_val = '0; limit = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        e = {2'd0, 1'b0, 1'b0, 4'd0};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL reset_p1 got %h exp %h", obs1, e); end
        checks++; if (obs3 !== e) begin errors++; $display("FAIL reset_p3 got %h exp %h", obs3, e); end
        load_val = 4'd3; limit = 4'd9; dir = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int v = 4; v <= 6; v++) tick();
        e = {2'd1, 1'b1, 1'b0, 4'd6};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL midrun_pre got %h exp %h", obs1, e); end
        reset = 1'b1;
        tick(); reset = 1'b0;
        e = {2'd0, 1'b0, 1'b0, 4'd0};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL midrun_reset got %h exp %h", obs1, e); end
        tick();
        checks++; if (obs1 !== e) begin errors++; $display("FAIL midrun_after got %h exp %h", obs1, e); end
    endtask

    task automatic test_basic_up();
        do_reset();
        load_val = 4'd2; limit = 4'd5; dir = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int v = 2; v <= 5; v++) begin
            if (v > 2) tick();
            e = {2'd1, 1'b1, 1'b0, 4'(v)};
            checks++; if (obs1 !== e) begin errors++; $display("FAIL basic_up y%0d got %h exp %h", v, obs1, e); end
        end
        tick();
        e = {2'd3, 1'b0, 1'b1, 4'd5};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL basic_up_done got %h exp %h", obs1, e); end
        tick();
        e = {2'd3, 1'b0, 1'b0, 4'd5};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL basic_up_hold got %h exp %h", obs1, e); end
    endtask

    task automatic test_down_reload();
        logic [3:0] seq [4];
        seq = '{4'd0, 4'd15, 4'd14, 4'd1};
        do_reset();
        load_val = 4'd1; limit = 4'd14; dir = 1'b0; auto_reload = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        e = {2'd1, 1'b1, 1'b0, 4'd1};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL down_start got %h exp %h", obs1, e); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                e = {2'd1, 1'b1, (i == 3), seq[i]};
                checks++; if (obs1 !== e) begin errors++; $display("FAIL down_reload r%0d i%0d got %h exp %h", r, i, obs1, e); end
            end
        end
    endtask

    task automatic test_prescale_pause();
        // one entry per edge after the start edge: {state, y}
        logic [5:0] tbl [21];
        tbl = '{{2'd1,4'd0}, {2'd1,4'd0}, {2'd1,4'd1}, {2'd1,4'd1}, {2'd1,4'd1},
                {2'd1,4'd2}, {2'd1,4'd2},
                {2'd2,4'd2}, {2'd2,4'd2}, {2'd2,4'd2}, {2'd2,4'd2}, {2'd2,4'd2},
                {2'd1,4'd2}, {2'd1,4'd2}, {2'd1,4'd3}, {2'd1,4'd3}, {2'd1,4'd3},
                {2'd1,4'd4}, {2'd1,4'd4}, {2'd1,4'd4}, {2'd3,4'd4}};
        do_reset();
        load_val = 4'd0; limit = 4'd4; dir = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        e = {2'd1, 1'b1, 1'b0, 4'd0};
        checks++; if (obs3 !== e) begin errors++; $display("FAIL pre_start got %h exp %h", obs3, e); end
        for (int i = 0; i < 21; i++) begin
            stop  = (i >= 7 && i <= 11);
            start = (i == 12);
            tick();
            e = {tbl[i][5:4], (tbl[i][5:4] != 2'd3), (i == 20), tbl[i][3:0]};
            checks++; if (obs3 !== e) begin errors++; $display("FAIL prescale_pause edge%0d got %h exp %h", i + 1, obs3, e); end
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        load_val = 4'd0; limit = 4'd10; dir = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        e = {2'd2, 1'b1, 1'b0, 4'd1};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_run_stop got %h exp %h", obs1, e); end
        tick();
        checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_pause_both got %h exp %h", obs1, e); end
        stop = 1'b0;
        tick();
        e = {2'd1, 1'b1, 1'b0, 4'd1};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_resume got %h exp %h", obs1, e); end
        load_val = 4'd9; limit = 4'd2; dir = 1'b0; auto_reload = 1'b1;
        for (int v = 2; v <= 10; v++) begin
            tick();
            start = 1'b0;
            e = {2'd1, 1'b1, 1'b0, 4'(v)};
            checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_norecap y%0d got %h exp %h", v, obs1, e); end
        end
        tick();
        e = {2'd3, 1'b0, 1'b1, 4'd10};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_done got %h exp %h", obs1, e); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0;
        e = {2'd0, 1'b0, 1'b0, 4'd10};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_done_both got %h exp %h", obs1, e); end
        tick();
        stop = 1'b0;
        checks++; if (obs1 !== e) begin errors++; $display("FAIL prio_idle_stop got %h exp %h", obs1, e); end
    endtask

    task automatic test_equal_limit();
        do_reset();
        load_val = 4'd7; limit = 4'd7; dir = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        e = {2'd1, 1'b1, 1'b0, 4'd7};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL eq_start got %h exp %h", obs1, e); end
        tick();
        e = {2'd3, 1'b0, 1'b1, 4'd7};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL eq_done got %h exp %h", obs1, e); end
    endtask

    task automatic test_wrap_up();
        do_reset();
        load_val = 4'd12; limit = 4'd3; dir = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int v = 13; v <= 19; v++) begin
            tick();
            e = {2'd1, 1'b1, 1'b0, 4'(v)};
            checks++; if (obs1 !== e) begin errors++; $display("FAIL wrap_up step%0d got %h exp %h", v, obs1, e); end
        end
        tick();
        e = {2'd3, 1'b0, 1'b1, 4'd3};
        checks++; if (obs1 !== e) begin errors++; $display("FAIL wrap_up_done got %h exp %h", obs1, e); end
    endtask

    initial begin
        test_reset();
        test_basic_up();
        test_down_reload();
        test_prescale_pause();
        test_priority();
        test_equal_limit();
        test_wrap_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
